// File: rtl/ekf_state_mem.sv
// ekf_state_mem
// -----------------------------------------------------------------------------
// Shared state/covariance store for the EKF stages. Holds the state vector x
// and the P, Q and R matrices (row-major) in one flat word array:
//
//   x : [0            .. STATE_DIM-1]
//   P : [P_BASE       .. P_BASE + STATE_DIM^2 - 1]
//   Q : [Q_BASE       .. Q_BASE + STATE_DIM^2 - 1]
//   R : [R_BASE       .. R_BASE + MEAS_DIM^2  - 1]
//
// After reset (or an init_start pulse) the array is filled one word per cycle:
// x is cleared and P/Q/R get their diagonal constant on the diagonal, 0
// elsewhere. Once filled, the engine port is served with 1-cycle registered
// reads and write-to-read bypass. A low-priority host port can load tuning
// values whenever the engine is not writing.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   init_start          pulse: restart initialisation
//   ready               memory initialised and serving the engine
//   mem_addr_rd         engine read address
//   mem_data_rd         registered read data (0 while initialising / out of range)
//   mem_addr_wr         engine write address
//   mem_data_wr         engine write data
//   mem_we              engine write enable
//   host_we             host write request (held until host_ack)
//   host_addr           host write address
//   host_wdata          host write data
//   host_ack            one-cycle pulse: host write committed (or dropped as OOB)
//   err_oob             sticky: an out-of-range address was used
// -----------------------------------------------------------------------------
module ekf_state_mem #(
    parameter int unsigned DATA_WIDTH                = 32,
    parameter int unsigned STATE_DIM                 = 4,
    parameter int unsigned MEAS_DIM                  = 2,
    parameter logic [DATA_WIDTH-1:0] P0_DIAG         = 32'h0001_0000,
    parameter logic [DATA_WIDTH-1:0] Q_DIAG          = 32'h0000_0148,
    parameter logic [DATA_WIDTH-1:0] R_DIAG          = 32'h0000_8000,
    parameter int unsigned TOTAL_MEM_SIZE            = STATE_DIM + 2 * STATE_DIM * STATE_DIM
                                                       + MEAS_DIM * MEAS_DIM,
    parameter int unsigned AW                        = $clog2(TOTAL_MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_start,
    output logic                  ready,
    input  logic [AW-1:0]         mem_addr_rd,
    output logic [DATA_WIDTH-1:0] mem_data_rd,
    input  logic [AW-1:0]         mem_addr_wr,
    input  logic [DATA_WIDTH-1:0] mem_data_wr,
    input  logic                  mem_we,
    input  logic                  host_we,
    input  logic [AW-1:0]         host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic                  err_oob
);

    localparam int unsigned P_BASE = STATE_DIM;
    localparam int unsigned Q_BASE = P_BASE + STATE_DIM * STATE_DIM;
    localparam int unsigned R_BASE = Q_BASE + STATE_DIM * STATE_DIM;

    localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL_MEM_SIZE - 1);

    typedef enum logic [0:0] {
        StInit,
        StReady
    } state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    host_ack_q, host_ack_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [TOTAL_MEM_SIZE];

    // Single internal write port shared by init, engine and host.
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    logic                    rd_oob;
    logic                    eng_oob;
    logic                    host_oob;
    logic                    host_commit;

    // Initial contents of word a. Diagonal elements of a row-major dim x dim
    // matrix sit at offsets that are multiples of (dim + 1).
    function automatic logic [DATA_WIDTH-1:0] init_value(input logic [AW-1:0] a);
        int unsigned ai;
        int unsigned off;
        logic [DATA_WIDTH-1:0] v;
        ai  = 32'(a);
        v   = '0;
        off = 0;
        if (ai >= R_BASE) begin
            off = ai - R_BASE;
            if ((off % (MEAS_DIM + 1)) == 0) v = R_DIAG;
        end else if (ai >= Q_BASE) begin
            off = ai - Q_BASE;
            if ((off % (STATE_DIM + 1)) == 0) v = Q_DIAG;
        end else if (ai >= P_BASE) begin
            off = ai - P_BASE;
            if ((off % (STATE_DIM + 1)) == 0) v = P0_DIAG;
        end
        return v;
    endfunction

    assign rd_oob   = (mem_addr_rd > LAST_ADDR);
    assign eng_oob  = (mem_addr_wr > LAST_ADDR);
    assign host_oob = (host_addr > LAST_ADDR);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_data_d   = '0;
        host_ack_d  = 1'b0;
        err_d       = err_q;
        wr_en       = 1'b0;
        wr_addr     = cnt_q;
        wr_data     = init_value(cnt_q);
        host_commit = 1'b0;

        unique case (state_q)
            StInit: begin
                // Engine/host traffic is ignored; reads stay forced to 0.
                wr_en = 1'b1;
                if (init_start) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StReady: begin
                // Host only gets the port in cycles the engine leaves free.
                host_commit = host_we && !mem_we;
                host_ack_d  = host_commit;

                if (mem_we) begin
                    wr_en   = !eng_oob;
                    wr_addr = mem_addr_wr;
                    wr_data = mem_data_wr;
                end else if (host_commit) begin
                    wr_en   = !host_oob;
                    wr_addr = host_addr;
                    wr_data = host_wdata;
                end

                if (rd_oob || (mem_we && eng_oob) || (host_commit && host_oob)) begin
                    err_d = 1'b1;
                end

                if (rd_oob) begin
                    rd_data_d = '0;
                end else if (wr_en && (wr_addr == mem_addr_rd)) begin
                    rd_data_d = wr_data;
                end else begin
                    rd_data_d = mem[mem_addr_rd];
                end

                if (init_start) begin
                    state_d = StInit;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            host_ack_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            host_ack_q <= host_ack_d;
            err_q      <= err_d;
        end
    end

    // Array contents are deliberately not reset; INIT rewrites every word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign ready       = (state_q == StReady);
    assign mem_data_rd = rd_data_q;
    assign host_ack    = host_ack_q;
    assign err_oob     = err_q;

endmodule

// File: tb/tb_ekf_state_mem.sv
// Directed bench for ekf_state_mem. Expected read data is pushed to a queue
// when a read address is driven and popped/compared one cycle later; a
// bench-side model of the memory map supplies the expected values.
module tb_ekf_state_mem;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 6;
    localparam int unsigned SIZE = 40;

    localparam logic [31:0] P0 = 32'h0001_0000;
    localparam logic [31:0] QD = 32'h0000_0148;
    localparam logic [31:0] RD = 32'h0000_8000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_start;
    logic          ready;
    logic [AW-1:0] mem_addr_rd;
    logic [DW-1:0] mem_data_rd;
    logic [AW-1:0] mem_addr_wr;
    logic [DW-1:0] mem_data_wr;
    logic          mem_we;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic          err_oob;

    ekf_state_mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_start  (init_start),
        .ready       (ready),
        .mem_addr_rd (mem_addr_rd),
        .mem_data_rd (mem_data_rd),
        .mem_addr_wr (mem_addr_wr),
        .mem_data_wr (mem_data_wr),
        .mem_we      (mem_we),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .err_oob     (err_oob)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [31:0] model [SIZE];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference contents after init, derived from (row, col) of each matrix.
    function automatic logic [31:0] init_val(input int a);
        int off;
        if (a < 4) return 32'h0;
        if (a < 20) begin
            off = a - 4;
            return (off / 4 == off % 4) ? P0 : 32'h0;
        end
        if (a < 36) begin
            off = a - 20;
            return (off / 4 == off % 4) ? QD : 32'h0;
        end
        off = a - 36;
        return (off / 2 == off % 2) ? RD : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        rd_exp_t e;
        @(posedge clk);
        #1;
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            check(e.tag, mem_data_rd, e.exp);
        end
    endtask

    task automatic expect_read(input string tag, input logic [AW-1:0] a, input bit forced_zero);
        rd_exp_t e;
        mem_addr_rd = a;
        e.tag = tag;
        e.exp = (forced_zero || a >= SIZE) ? 32'h0 : model[a];
        rd_q.push_back(e);
    endtask

    task automatic wait_ready(input string tag);
        int cyc;
        cyc = 0;
        while (ready !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
        end
        check(tag, cyc, 40);
    endtask

    initial begin
        rst_n       = 1'b0;
        init_start  = 1'b0;
        mem_addr_rd = '0;
        mem_addr_wr = '0;
        mem_data_wr = '0;
        mem_we      = 1'b0;
        host_we     = 1'b0;
        host_addr   = '0;
        host_wdata  = '0;
        for (int i = 0; i < SIZE; i++) model[i] = init_val(i);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_rdata", mem_data_rd, 0);
        check("rst_ack", host_ack, 0);
        check("rst_err", err_oob, 0);

        rst_n = 1'b1;
        wait_ready("ready_after_reset");

        // Initial contents
        expect_read("init_rd4", 4, 0);   step();
        expect_read("init_rd5", 5, 0);   step();
        expect_read("init_rd20", 20, 0); step();
        expect_read("init_rd25", 25, 0); step();
        expect_read("init_rd37", 37, 0); step();
        expect_read("init_rd39", 39, 0); step();
        expect_read("init_rd0", 0, 0);   step();

        // Engine write with read of the same address: bypass
        mem_we = 1'b1; mem_addr_wr = 2; mem_data_wr = 32'h0003_0000;
        model[2] = 32'h0003_0000;
        expect_read("bypass_eng", 2, 0);
        step();
        mem_we = 1'b0;
        expect_read("reread_2", 2, 0);
        step();

        // Host write stalled behind 3 cycles of engine writes
        host_we = 1'b1; host_addr = 36; host_wdata = 32'h0000_4000;
        mem_we = 1'b1; mem_addr_wr = 1; mem_data_wr = 32'h0000_0111;
        model[1] = 32'h0000_0111;
        for (int i = 0; i < 3; i++) begin
            step();
            check("host_stall_ack", host_ack, 0);
        end
        mem_we = 1'b0;
        model[36] = 32'h0000_4000;
        step();
        check("host_ack", host_ack, 1);
        host_we = 1'b0;
        step();
        check("host_ack_pulse", host_ack, 0);
        expect_read("rd_host36", 36, 0); step();
        expect_read("rd_eng1", 1, 0);    step();

        // Host write bypass
        host_we = 1'b1; host_addr = 10; host_wdata = 32'hdead_beef;
        model[10] = 32'hdead_beef;
        expect_read("bypass_host", 10, 0);
        step();
        host_we = 1'b0;
        check("host_ack_byp", host_ack, 1);

        // Same-address collision: engine commits, host retries next cycle
        host_we = 1'b1; host_addr = 12; host_wdata = 32'h0000_2222;
        mem_we = 1'b1; mem_addr_wr = 12; mem_data_wr = 32'h0000_1111;
        model[12] = 32'h0000_1111;
        expect_read("collide_eng", 12, 0);
        step();
        check("collide_no_ack", host_ack, 0);
        mem_we = 1'b0;
        model[12] = 32'h0000_2222;
        expect_read("collide_host_byp", 12, 0);
        step();
        check("collide_ack", host_ack, 1);
        host_we = 1'b0;
        expect_read("collide_final", 12, 0);
        step();

        // Out-of-range read
        check("err_before_oob", err_oob, 0);
        mem_we = 1'b1; mem_addr_wr = 0; mem_data_wr = 32'h0001_0000;
        model[0] = 32'h0001_0000;
        step();
        mem_we = 1'b0;
        expect_read("rd_oob45", 45, 0);
        step();
        mem_addr_rd = 0;
        check("err_rd_oob", err_oob, 1);
        expect_read("rd0_modified", 0, 0);
        step();

        // Re-initialise; engine and host traffic during INIT must be ignored
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        check("init_ready_low", ready, 0);
        check("init_err_clear", err_oob, 0);
        mem_we = 1'b1; mem_addr_wr = 0; mem_data_wr = 32'hffff_ffff;
        host_we = 1'b1; host_addr = 7; host_wdata = 32'h1234_5678;
        begin
            int cyc;
            cyc = 0;
            while (ready !== 1'b1 && cyc < 60) begin
                expect_read("init_rd_forced0", 4, 1);
                step();
                cyc++;
                check("init_no_ack", host_ack, 0);
            end
            check("ready_after_init_start", cyc, 40);
        end
        mem_we = 1'b0;
        host_we = 1'b0;
        mem_addr_rd = 0;
        for (int i = 0; i < SIZE; i++) model[i] = init_val(i);
        expect_read("reinit_rd0", 0, 0); step();
        expect_read("reinit_rd7", 7, 0); step();
        expect_read("reinit_rd4", 4, 0); step();

        // Out-of-range engine write: dropped, flag set, array untouched
        check("err_before_wr_oob", err_oob, 0);
        mem_we = 1'b1; mem_addr_wr = 63; mem_data_wr = 32'h5555_5555;
        step();
        mem_we = 1'b0;
        check("err_wr_oob", err_oob, 1);
        for (int i = 0; i < SIZE; i++) begin
            expect_read("oob_wr_untouched", AW'(i), 0);
            step();
        end

        // Out-of-range host write still acknowledged
        host_we = 1'b1; host_addr = 50; host_wdata = 32'h7777_7777;
        step();
        host_we = 1'b0;
        check("host_oob_ack", host_ack, 1);
        check("host_oob_err", err_oob, 1);

        // Reset pulse at INIT cycle 15
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        repeat (15) step();
        check("mid_init_ready", ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready", ready, 0);
        check("async_rst_rdata", mem_data_rd, 0);
        check("async_rst_err", err_oob, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready("ready_after_mid_reset");
        expect_read("post_reset_rd20", 20, 0); step();
        expect_read("post_reset_rd39", 39, 0); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
